cga_alu_ralu_seq: RTL and testbench

- Parametrised, registered successor of the CPU RALU.
- Holds a WIDTH-bit operand-select / add / logic datapath with registered result and flags.
- Adds a chained-carry mode for multi-precision arithmetic and an iterative shift-add unsigned multiplier with a START/BUSY/DONE handshake.
- Sits between the register-file read ports (RN, S) and the ALU result bus.

---
 rtl/cga_alu_ralu_seq.sv | 182 ++++++++++++++++++
 tb/tb_cga_alu_ralu_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_alu_ralu_seq.sv
// cga_alu_ralu_seq
// Registered operand-select / add / logic datapath that sits between the
// register-file read ports (RN, S) and the ALU result bus. It also holds an
// iterative shift-add unsigned multiplier.
//
// Ports:
//   sysclk, sys_rst      clock (rising edge); synchronous active-high reset
//   START, OP            request (sampled only in IDLE); 0 = ALU op, 1 = multiply
//   RN, S                A / B operands (WIDTH bits)
//   RSN, ALUI4           invert the A / B operand paths
//   LOG, FSEL            logic result select; logic function (0 = AND, 1 = XOR)
//   CI, CSEL             external carry-in; 1 = chain from the registered CRY
//   BUSY, DONE           multiply in progress; one-cycle result-valid pulse
//   F, FH                result, or product low half / product high half
//   CRY, OVF, SGR, ZF    carry, overflow, signed-greater and zero flags
//
// ALU ops complete in one edge and never raise BUSY. A multiply latches its
// operands, then runs WIDTH shift-add steps. The final step writes {FH,F} and
// the flags. Results hold between operations and while a multiply runs.
module cga_alu_ralu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] RN,
    input  logic [WIDTH-1:0] S,
    input  logic             RSN,
    input  logic             ALUI4,
    input  logic             LOG,
    input  logic             FSEL,
    input  logic             CI,
    input  logic             CSEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] FH,
    output logic             CRY,
    output logic             OVF,
    output logic             SGR,
    output logic             ZF
);

    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic [WIDTH-1:0]   fh_q, fh_d;
    logic               cry_q, cry_d;
    logic               ovf_q, ovf_d;
    logic               sgr_q, sgr_d;
    logic               zf_q, zf_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   a, b, logic_res, alu_f;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Operand mux, adder and logic unit
    always_comb begin
        a         = RSN ? ~RN : RN;
        b         = ALUI4 ? ~S : S;
        cin       = CSEL ? cry_q : CI;
        sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        logic_res = FSEL ? (a ^ b) : (a & b);
        alu_f     = LOG ? logic_res : sum[WIDTH-1:0];
    end

    // One shift-add step. The upper half accumulates partial products. The
    // lower half starts as the multiplier and is consumed LSB-first as the
    // product shifts in from above. After WIDTH steps {hi,lo} = A*B.
    always_comb begin
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_step = {step_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        fh_d    = fh_q;
        cry_d   = cry_q;
        ovf_d   = ovf_q;
        sgr_d   = sgr_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (OP && MUL_EN) begin
                        state_d = S_MUL;
                        mcand_d = a;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        cnt_d   = '0;
                    end else begin
                        f_d    = alu_f;
                        fh_d   = '0;
                        cry_d  = ~LOG & sum[WIDTH];
                        // Overflow always comes from the adder, even when
                        // the logic result is selected.
                        ovf_d  = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
                        sgr_d  = (~a[MSB] & ~b[MSB]) | (~a[MSB] & ~alu_f[MSB])
                               | (~b[MSB] & ~alu_f[MSB]);
                        zf_d   = (alu_f == '0);
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    f_d     = acc_step[WIDTH-1:0];
                    fh_d    = acc_step[2*WIDTH-1:WIDTH];
                    cry_d   = 1'b0;
                    ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
                    sgr_d   = 1'b0;
                    zf_d    = ~|acc_step;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            fh_q    <= '0;
            cry_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sgr_q   <= 1'b0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            fh_q    <= fh_d;
            cry_q   <= cry_d;
            ovf_q   <= ovf_d;
            sgr_q   <= sgr_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY = (state_q == S_MUL);
    assign DONE = done_q;
    assign F    = f_q;
    assign FH   = fh_q;
    assign CRY  = cry_q;
    assign OVF  = ovf_q;
    assign SGR  = sgr_q;
    assign ZF   = zf_q;

endmodule

// File: tb/tb_cga_alu_ralu_seq.sv
// Bench for cga_alu_ralu_seq. It runs a WIDTH=16 and a WIDTH=8 instance
// one after the other. The instances share the reset.
// Expected results come from an arithmetic model and are queued at issue
// time. A negedge monitor pops the queue on every DONE and compares the
// outputs and the cycle of arrival.
module tb_cga_alu_ralu_seq;

    typedef struct packed {
        logic        busy;
        logic [15:0] f;
        logic [15:0] fh;
        logic        cry;
        logic        ovf;
        logic        sgr;
        logic        zf;
    } res_t;

    typedef struct packed {
        int   cyc;
        res_t r;
    } exp_t;

    logic sysclk  = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        start[2], op[2], rsn[2], alui4[2], lg[2], fsel[2], ci[2], csel[2];
    logic [15:0] rn[2], s[2];

    logic        a_busy, a_done, a_cry, a_ovf, a_sgr, a_zf;
    logic [15:0] a_f, a_fh;
    logic        b_busy, b_done, b_cry, b_ovf, b_sgr, b_zf;
    logic [7:0]  b_f, b_fh;

    cga_alu_ralu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut16 (
        .sysclk(sysclk), .sys_rst(sys_rst), .START(start[0]), .OP(op[0]),
        .RN(rn[0]), .S(s[0]), .RSN(rsn[0]), .ALUI4(alui4[0]), .LOG(lg[0]),
        .FSEL(fsel[0]), .CI(ci[0]), .CSEL(csel[0]), .BUSY(a_busy), .DONE(a_done),
        .F(a_f), .FH(a_fh), .CRY(a_cry), .OVF(a_ovf), .SGR(a_sgr), .ZF(a_zf)
    );

    cga_alu_ralu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
        .sysclk(sysclk), .sys_rst(sys_rst), .START(start[1]), .OP(op[1]),
        .RN(rn[1][7:0]), .S(s[1][7:0]), .RSN(rsn[1]), .ALUI4(alui4[1]), .LOG(lg[1]),
        .FSEL(fsel[1]), .CI(ci[1]), .CSEL(csel[1]), .BUSY(b_busy), .DONE(b_done),
        .F(b_f), .FH(b_fh), .CRY(b_cry), .OVF(b_ovf), .SGR(b_sgr), .ZF(b_zf)
    );

    exp_t q0[$], q1[$];
    bit   cry_m[2];
    res_t last[2];
    logic [15:0] corners[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    function automatic int wd(int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic res_t snap(int d);
        res_t r;
        if (d == 0) r = {a_busy, a_f, a_fh, a_cry, a_ovf, a_sgr, a_zf};
        else        r = {b_busy, 8'h00, b_f, 8'h00, b_fh, b_cry, b_ovf, b_sgr, b_zf};
        return r;
    endfunction

    function automatic logic done_of(int d);
        return (d == 0) ? a_done : b_done;
    endfunction

    function automatic void push(int d, exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on w-bit values
    function automatic res_t model(int w, bit o, logic [15:0] r, logic [15:0] sv,
                                   bit rs, bit ai, bit lgc, bit fs, bit cin);
        longint m, a, b, sum, p;
        bit am, bm, fm, sm;
        res_t e;
        m = (longint'(1) << w) - 1;
        a = (rs ? ~longint'(r)  : longint'(r))  & m;
        b = (ai ? ~longint'(sv) : longint'(sv)) & m;
        e = '0;
        if (o) begin
            p     = a * b;
            e.f   = 16'(p & m);
            e.fh  = 16'((p >> w) & m);
            e.ovf = ((p >> w) != 0);
            e.zf  = (p == 0);
        end else begin
            sum   = a + b + longint'(cin);
            e.f   = 16'(lgc ? (fs ? (a ^ b) : (a & b)) : (sum & m));
            e.cry = !lgc && (((sum >> w) & 1) != 0);
            am    = ((a >> (w - 1)) & 1) != 0;
            bm    = ((b >> (w - 1)) & 1) != 0;
            sm    = ((sum >> (w - 1)) & 1) != 0;
            fm    = ((longint'(e.f) >> (w - 1)) & 1) != 0;
            e.ovf = (am == bm) && (sm != am);
            e.sgr = (int'(!am) + int'(!bm) + int'(!fm)) >= 2;
            e.zf  = (e.f == 0);
        end
        return e;
    endfunction

    // fl = {RSN, ALUI4, LOG, FSEL, CI, CSEL}. Called #1 after a rising edge
    // or at a falling edge. Returns after the completing edge, so a
    // following call issues back-to-back in the DONE cycle.
    // inj_at / rst_at: multiply step at which a stray START or a reset lands.
    task automatic issue(input int d, input bit o, input logic [15:0] r, input logic [15:0] sv,
                         input logic [5:0] fl, input int inj_at, input int rst_at);
        int   w;
        exp_t e;
        res_t held;
        w = wd(d);
        rn[d] = r; s[d] = sv; op[d] = o;
        {rsn[d], alui4[d], lg[d], fsel[d], ci[d], csel[d]} = fl;
        start[d] = 1'b1;
        e.r   = model(w, o, r, sv, fl[5], fl[4], fl[3], fl[2], fl[0] ? cry_m[d] : fl[1]);
        e.cyc = cyc + 1 + (o ? w : 0);
        held     = last[d];
        last[d]  = e.r;
        cry_m[d] = e.r.cry;
        push(d, e);
        @(posedge sysclk); #1;
        start[d] = 1'b0;
        if (o) begin
            for (int i = 1; i <= w; i++) begin
                if (i == rst_at) begin
                    sys_rst = 1'b1;
                    @(posedge sysclk); #1;
                    sys_rst = 1'b0;
                    q0.delete(); q1.delete();
                    cry_m[0] = 1'b0; cry_m[1] = 1'b0;
                    last[0]  = '0;   last[1]  = '0;
                    @(negedge sysclk);
                    chk($sformatf("dut%0d state after mid-multiply reset", d),
                        {done_of(d), snap(d)}, 128'd0);
                    return;
                end
                if (i == inj_at) begin
                    start[d] = 1'b1;
                    op[d]    = 1'($urandom);
                end
                rn[d] = 16'($urandom);
                s[d]  = 16'($urandom);
                @(negedge sysclk);
                held.busy = 1'b1;
                chk($sformatf("dut%0d busy/hold step %0d", d, i), snap(d), held);
                @(posedge sysclk); #1;
                start[d] = 1'b0;
            end
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge sysclk);
            chk($sformatf("dut%0d idle hold", d), snap(d), last[d]);
            @(posedge sysclk); #1;
        end
    endtask

    function automatic logic [15:0] pick();
        int k;
        k = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) return corners[k];
        return 16'($urandom);
    endfunction

    // Monitor: every DONE must match the next queued expectation, in the
    // predicted cycle.
    always @(negedge sysclk) begin
        exp_t e;
        if (!sys_rst) begin
            for (int d = 0; d < 2; d++) begin
                if (done_of(d)) begin
                    if (qsize(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected DONE: got DONE=1 at cycle %0d, expected no DONE",
                                 d, cyc);
                    end else begin
                        e = pop(d);
                        chk($sformatf("dut%0d result {cycle,busy,F,FH,CRY,OVF,SGR,ZF}", d),
                            {cyc, snap(d)}, {e.cyc, e.r});
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; op[d] = 1'b0; rsn[d] = 1'b0; alui4[d] = 1'b0;
            lg[d] = 1'b0; fsel[d] = 1'b0; ci[d] = 1'b0; csel[d] = 1'b0;
            rn[d] = '0; s[d] = '0;
            cry_m[d] = 1'b0; last[d] = '0;
        end
        repeat (3) @(posedge sysclk);
        #1 sys_rst = 1'b0;
        @(negedge sysclk);
        chk("dut0 reset state", {done_of(0), snap(0)}, 128'd0);
        chk("dut1 reset state", {done_of(1), snap(1)}, 128'd0);
        @(posedge sysclk); #1;

        for (int d = 0; d < 2; d++) begin
            issue(d, 1'b0, 16'h1234, 16'h4321, 6'b000000, 0, 0);  // add
            issue(d, 1'b0, 16'hFFFF, 16'h0001, 6'b000000, 0, 0);  // carry + zero
            issue(d, 1'b0, 16'h0000, 16'h0000, 6'b000001, 0, 0);  // chained carry-in
            issue(d, 1'b0, 16'h7FFF, 16'h0001, 6'b000000, 0, 0);  // signed overflow
            issue(d, 1'b0, 16'h0005, 16'h0003, 6'b010010, 0, 0);  // subtract
            issue(d, 1'b0, 16'hF0F0, 16'hFF00, 6'b001100, 0, 0);  // XOR
            issue(d, 1'b0, 16'hF0F0, 16'hFF00, 6'b001000, 0, 0);  // AND
            idle(d, 2);
            issue(d, 1'b1, 16'h00FF, 16'h0101, 6'b000000, 0, 0);
            issue(d, 1'b1, 16'hFFFF, 16'hFFFF, 6'b000000, 0, 0);
            issue(d, 1'b0, 16'hFFFF, 16'h0000, 6'b000001, 0, 0);  // chain after multiply
            idle(d, 2);
            issue(d, 1'b1, 16'h1234, 16'h0567, 6'b000000, 5, 0);  // stray START ignored
            idle(d, 3);
            issue(d, 1'b1, 16'hABCD, 16'h1357, 6'b000000, 0, 8);  // reset mid-multiply
            issue(d, 1'b0, 16'h0100, 16'h0200, 6'b000001, 0, 0);  // chain after reset
            for (int n = 0; n < 60; n++) begin
                bit o;
                int inj;
                o   = ($urandom_range(0, 3) == 0);
                inj = o ? int'($urandom_range(0, wd(d))) : 0;
                issue(d, o, pick(), pick(), 6'($urandom), inj, 0);
                if ($urandom_range(0, 4) == 0) idle(d, int'($urandom_range(1, 3)));
            end
            idle(d, 3);
        end

        chk("dut0 outstanding results", 128'(q0.size()), 128'd0);
        chk("dut1 outstanding results", 128'(q1.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
